serial_subtractor8: RTL and testbench

- Bit-serial W-bit subtractor: computes diff = a - b - bin, LSB first, one bit per clock, through a single 1-bit full-subtractor cell.
- Complements the existing ripple-carry adder family by providing subtraction.
- Trades latency for area.
- Sits as a multi-cycle arithmetic slave behind a start/ready/done handshake.

---
 rtl/serial_subtractor_pkg.sv | 19 +
 rtl/fullsub1.sv | 13 +
 rtl/serial_subtractor8.sv | 124 ++++++++++++
 tb/tb_serial_subtractor8.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Optional signed-overflow output is enabled with SERIAL_SUBTRACTOR_OVF_EN.
package serial_subtractor_pkg;

    // Controller states: waiting for a request, shifting bits, result pulse.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sersub_state_t;

    localparam int SERSUB_W_DEFAULT = 8;

    // Width of a counter that must reach w-1; never narrower than one bit.
    function automatic int sersub_cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fullsub1.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
module fullsub1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor8.sv
// Bit-serial W-bit subtractor: diff = a - b - bin, LSB first, one bit per clock
// through a single fullsub1 cell, behind a start/ready/done handshake.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor8
    import serial_subtractor_pkg::*;
#(
    parameter int W = SERSUB_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic         ovf,
`endif
    output logic         bout
);

    localparam int CW = sersub_cnt_w(W);

    sersub_state_t state;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  res_sr;
    logic          brw;
    logic [CW-1:0] cnt;
    logic          d_bit;
    logic          brw_next;
    logic          last_bit;
    logic [W-1:0]  res_next;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    // The single shared subtractor cell always works on the operand LSBs.
    fullsub1 u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (d_bit),
        .bout (brw_next)
    );

    assign last_bit = (cnt == CW'(W - 1));
    assign res_next = {d_bit, res_sr[W-1:1]};

    // Controller, datapath shift registers and registered handshake/result outputs.
    // NOTE: every register here is sequential state, so all assignments are
    // non-blocking; blocking ones would let later statements see updated values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= bin;
                        cnt   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        a_msb <= a[W-1];
                        b_msb <= b[W-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    brw    <= brw_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= res_next;
                        bout  <= brw_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf   <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor8.sv
// Self-checking bench for serial_subtractor8 (W=8) with an expected-result queue.
// Build with SERIAL_SUBTRACTOR_OVF_EN defined to also exercise the ovf output.
module tb_serial_subtractor8;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    serial_subtractor8 #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares the handshake outputs against expected levels.
    task automatic chk_ctrl(input string name, input logic er, input logic eb, input logic ed);
        n_vec++;
        if ({ready, busy, done} !== {er, eb, ed}) begin
            n_err++;
            $display("FAIL %s: ready/busy/done got %b%b%b expected %b%b%b at %0t",
                     name, ready, busy, done, er, eb, ed, $time);
        end
    endtask

    // Compares the result outputs against the oldest queued expectation.
    task automatic chk_result(input string name);
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: result produced with empty scoreboard", name);
            return;
        end
        e = sb_q.pop_front();
        if (diff !== e.diff || bout !== e.bout) begin
            n_err++;
            $display("FAIL %s: diff/bout got %h/%b expected %h/%b", name, diff, bout, e.diff, e.bout);
        end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        n_vec++;
        if (ovf !== e.ovf) begin
            n_err++;
            $display("FAIL %s: ovf got %b expected %b", name, ovf, e.ovf);
        end
`endif
    endtask

    // Runs one operation from a negedge with ready=1; optionally keeps start high
    // throughout and changes a/b mid-operation to prove they are ignored.
    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bv_in, input bit hold);
        exp_t e;
        int   s;
        int   ss;
        s      = int'(av) - int'(bv) - int'(bv_in);
        e.diff = s[W-1:0];
        e.bout = (s < 0);
        ss     = int'($signed(av)) - int'($signed(bv)) - int'(bv_in);
        e.ovf  = (ss > 127) || (ss < -128);
        sb_q.push_back(e);

        a = av; b = bv; bin = bv_in; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            start = 1'b0;
            a = 8'hA5; b = 8'h5A; bin = ~bv_in;
        end
        chk_ctrl({name, "_e0"}, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k < W; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (hold && k == 2) begin
                a = 8'h10; b = 8'h01;
            end
            chk_ctrl({name, "_shift"}, 1'b0, 1'b1, 1'b0);
        end
        @(posedge clk);
        @(negedge clk);
        chk_ctrl({name, "_done"}, 1'b0, 1'b0, 1'b1);
        chk_result(name);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_ctrl({name, "_idle"}, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_ctrl("reset_idle", 1'b1, 1'b0, 1'b0);
            n_vec++;
            if (diff !== 8'h00 || bout !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle: diff/bout got %h/%b expected 00/0", diff, bout);
            end
        end
    endtask

    task automatic test_basic();
        run_op("sub_05_03", 8'h05, 8'h03, 1'b0, 1'b0);
        run_op("sub_03_05", 8'h03, 8'h05, 1'b0, 1'b0);
        run_op("sub_00_00_b", 8'h00, 8'h00, 1'b1, 1'b0);
        run_op("sub_ff_ff_b", 8'hFF, 8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_ovf_vectors();
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b0);
        run_op("sub_7f_ff", 8'h7F, 8'hFF, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_op("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic test_ignore_start();
        run_op("held_start", 8'h05, 8'h03, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        a = 8'h44; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_ctrl("abort_now", 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (diff !== 8'h00 || bout !== 1'b0) begin
            n_err++;
            $display("FAIL abort_now: diff/bout got %h/%b expected 00/0", diff, bout);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_ctrl("abort_hold", 1'b1, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_abort", 8'h20, 8'h01, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        test_ovf_vectors();
`endif
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d results never produced, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
